// File: rtl/w0rm_core_writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: width helper, default sizes and
// the source selector used when steering a granted result to the output stage.
package w0rm_core_writeback_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_NUM_REGISTERS = 16;
    localparam int DEFAULT_STARVE_LIMIT  = 4;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    // Ceiling log2, never returning less than 1 so a one-entry range still gets a bit.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

    localparam int DEFAULT_ADDR_WIDTH = log2_ceil(DEFAULT_NUM_REGISTERS);

endpackage

// File: rtl/w0rm_core_writeback_arbiter_if.sv
// Handshake bundle between the ALU/memory sources, the arbiter and the register
// file write port. The master side is the environment, the slave side the arbiter.
interface w0rm_core_writeback_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          flush;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] port_write_addr;
    logic [DW-1:0] port_write_data;
    logic          port_write_enable;
    logic          starve_active;

    modport master (
        output flush, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, port_write_addr, port_write_data,
               port_write_enable, starve_active
    );

    modport slave (
        input  flush, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, port_write_addr, port_write_data,
               port_write_enable, starve_active
    );
endinterface

// File: rtl/w0rm_core_wb_out_reg.sv
// Output register for the register-file write port. Enable pulses for one cycle per
// accepted result; addr/data hold their last values when nothing is loaded.
module w0rm_core_wb_out_reg #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          enable,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            addr   <= '0;
            data   <= '0;
        end else begin
            enable <= load && !flush;
            if (load && !flush) begin
                addr <= load_addr;
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/w0rm_core_writeback_arbiter.sv
// Writeback arbiter: grants one of ALU/memory per cycle into a registered write port,
// favouring memory but forcing an ALU grant after STARVE_LIMIT contested memory wins.
module w0rm_core_writeback_arbiter
    import w0rm_core_writeback_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
    parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
    input logic clk,
    input logic reset,
    w0rm_core_writeback_arbiter_if.slave bus
);

    localparam int ADDR_WIDTH = log2_ceil(NUM_REGISTERS);
    localparam int CW         = log2_ceil(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]         starve_cnt_reg;
    logic [CW-1:0]         starve_cnt_next;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  starve;
    logic                  contested;
    wb_src_e               src;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    assign contested = bus.alu_valid && bus.mem_valid;

    // Grants are forced low during reset so nothing is accepted that would be lost.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        starve    = 1'b0;
        src       = WB_ALU;
        if (!reset && !bus.flush) begin
            if (bus.mem_valid && (!bus.alu_valid || starve_cnt_reg < LIMIT)) begin
                mem_grant = 1'b1;
                src       = WB_MEM;
            end else if (bus.alu_valid) begin
                alu_grant = 1'b1;
                starve    = bus.mem_valid;
            end
        end
    end

    always_comb begin
        sel_addr = bus.alu_addr;
        sel_data = bus.alu_data;
        unique case (src)
            WB_MEM: begin
                sel_addr = bus.mem_addr;
                sel_data = bus.mem_data;
            end
            default: ;
        endcase
    end

    // Memory can only win a contested cycle below the limit, so +1 never overshoots it.
    always_comb begin
        starve_cnt_next = '0;
        if (!bus.flush && contested && mem_grant)
            starve_cnt_next = starve_cnt_reg + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_cnt_reg <= '0;
        else       starve_cnt_reg <= starve_cnt_next;
    end

    assign bus.alu_ready     = alu_grant;
    assign bus.mem_ready     = mem_grant;
    assign bus.starve_active = starve;

    w0rm_core_wb_out_reg #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .load      (alu_grant || mem_grant),
        .load_addr (sel_addr),
        .load_data (sel_data),
        .enable    (bus.port_write_enable),
        .addr      (bus.port_write_addr),
        .data      (bus.port_write_data)
    );

endmodule

// File: tb/tb_w0rm_core_writeback_arbiter.sv
// Directed bench for the writeback arbiter with a small behavioural register file
// fed by the write port.
module tb_w0rm_core_writeback_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [31:0] rf [16];

    w0rm_core_writeback_arbiter_if #(.DW(32), .AW(4)) bus ();

    w0rm_core_writeback_arbiter #(
        .DATA_WIDTH    (32),
        .NUM_REGISTERS (16),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.port_write_enable) rf[bus.port_write_addr] <= bus.port_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    string pat;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        reset = 1'b1;
        bus.flush     = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 32'h0000_00A2;
        bus.mem_valid = 1'b1; bus.mem_addr = 4'd1; bus.mem_data = 32'h0000_00A1;

        // 1: reset held with both sources valid
        tick(); tick();
        check("rst_alu_ready", {31'b0, bus.alu_ready}, 32'd0);
        check("rst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        check("rst_enable", {31'b0, bus.port_write_enable}, 32'd0);
        check("rst_addr", {28'b0, bus.port_write_addr}, 32'd0);
        check("rst_data", bus.port_write_data, 32'd0);
        check("rst_starve", {31'b0, bus.starve_active}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_mem_ready", {31'b0, bus.mem_ready}, 32'd1);
        tick();
        check("rel_enable", {31'b0, bus.port_write_enable}, 32'd1);
        check("rel_addr", {28'b0, bus.port_write_addr}, 32'd1);
        $display("txn release: first write addr=%0d data=%h", bus.port_write_addr, bus.port_write_data);
        idle();
        tick();

        // 2: ALU only
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        check("alu_only_ready", {31'b0, bus.alu_ready}, 32'd1);
        check("alu_only_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        tick();
        idle();
        check("alu_only_enable", {31'b0, bus.port_write_enable}, 32'd1);
        check("alu_only_addr", {28'b0, bus.port_write_addr}, 32'd3);
        check("alu_only_data", bus.port_write_data, 32'hDEAD_BEEF);
        tick();
        check("alu_only_r3", rf[3], 32'hDEAD_BEEF);
        check("alu_only_enable_off", {31'b0, bus.port_write_enable}, 32'd0);
        check("hold_data", bus.port_write_data, 32'hDEAD_BEEF);
        $display("txn alu_only: r3=%h", rf[3]);

        // 3: sustained dual-valid, expect MMMMAMMMMA
        pat = "MMMMAMMMMA";
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 32'h0000_0077;
        bus.mem_valid = 1'b1; bus.mem_addr = 4'd8; bus.mem_data = 32'h0000_0088;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("dual%0d_mem_ready", i), {31'b0, bus.mem_ready}, {31'b0, pat[i] == "M"});
            check($sformatf("dual%0d_alu_ready", i), {31'b0, bus.alu_ready}, {31'b0, pat[i] == "A"});
            check($sformatf("dual%0d_starve", i), {31'b0, bus.starve_active}, {31'b0, pat[i] == "A"});
            tick();
            check($sformatf("dual%0d_addr", i), {28'b0, bus.port_write_addr},
                  (pat[i] == "M") ? 32'd8 : 32'd7);
            $display("txn dual cycle %0d: grant %s addr=%0d", i + 1, (pat[i] == "M") ? "MEM" : "ALU",
                     bus.port_write_addr);
        end
        idle();
        tick();

        // 4: same destination on both sources
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 32'h0000_0022;
        bus.mem_valid = 1'b1; bus.mem_addr = 4'd5; bus.mem_data = 32'h0000_0011;
        tick();
        bus.mem_valid = 1'b0;
        check("same_first_data", bus.port_write_data, 32'h0000_0011);
        tick();
        bus.alu_valid = 1'b0;
        check("same_r5_first", rf[5], 32'h0000_0011);
        check("same_second_data", bus.port_write_data, 32'h0000_0022);
        tick();
        check("same_r5_second", rf[5], 32'h0000_0022);
        $display("txn same_dest: r5=%h", rf[5]);

        // 5: MEM grant then flush; flush must also clear the starvation count
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd9;  bus.alu_data = 32'h0000_0099;
        bus.mem_valid = 1'b1; bus.mem_addr = 4'd10; bus.mem_data = 32'h0000_0055;
        tick();
        bus.flush = 1'b1;
        #1;
        check("flush_alu_ready", {31'b0, bus.alu_ready}, 32'd0);
        check("flush_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        check("flush_prev_enable", {31'b0, bus.port_write_enable}, 32'd1);
        check("flush_prev_data", bus.port_write_data, 32'h0000_0055);
        tick();
        bus.flush = 1'b0;
        check("flush_enable_off", {31'b0, bus.port_write_enable}, 32'd0);
        check("flush_r10", rf[10], 32'h0000_0055);
        pat = "MMMMA";
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("postflush%0d_alu_ready", i), {31'b0, bus.alu_ready},
                  {31'b0, pat[i] == "A"});
            tick();
        end
        idle();
        tick();
        $display("txn flush: starvation count restarted after flush");

        // 6: async reset while a write is on the port
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd12; bus.alu_data = 32'h0000_00CC;
        tick();
        idle();
        check("rw_enable_before", {31'b0, bus.port_write_enable}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rw_enable_dropped", {31'b0, bus.port_write_enable}, 32'd0);
        check("rw_addr_cleared", {28'b0, bus.port_write_addr}, 32'd0);
        tick();
        check("rw_r12_untouched", rf[12], 32'd0);
        reset = 1'b0;
        tick();
        check("rw_r12_still", rf[12], 32'd0);
        $display("txn reset_mid_write: r12=%h", rf[12]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
